// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter (FSM states, LFSR seed, delay counter width)
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam logic [3:0] MEM_ARB_LFSR_SEED = 4'b1001;
    localparam int CNT_W = 9;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory-port signals of the arbiter
//   slave  : arbiter side (takes requests, drives responses and the memory strobe)
//   master : requester/memory side (drives requests and mem_rdata)
interface mem_arbiter_if;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wr, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_wr, lsu_addr, lsu_wdata, lsu_wstrb, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
    );
    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_wr, lsu_addr, lsu_wdata, lsu_wstrb, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arb_lfsr.sv
// mem_arb_lfsr: 4-bit LFSR (x^4+x^3+1) adding a random term to the access delay
//   clock, reset : clock and synchronous active-high reset (loads MEM_ARB_LFSR_SEED)
//   value        : current LFSR state, steps every cycle
// Only built when MEM_ARB_RAND_DELAY_EN is defined.
`ifdef MEM_ARB_RAND_DELAY_EN
module mem_arb_lfsr
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] value
);
    always_ff @(posedge clock)
        value <= reset ? MEM_ARB_LFSR_SEED : {value[2:0], value[3] ^ value[2]};
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter and sequencer for a single side-effecting memory port
//   clock, reset : clock and synchronous active-high reset
//   bus          : mem_arbiter_if.slave (IFU/LSU request+response channels, memory strobe port)
//   LATENCY      : cycles from accept to the single mem_en pulse (1..255)
// Define MEM_ARB_RAND_DELAY_EN to add a 0..15 LFSR term to each transaction's delay.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    state_t           state, state_nxt;
    logic             owner, last_lsu, gnt_ifu, gnt_lsu, acc, resp_hs;
    logic [CNT_W-1:0] cnt, dly;
`ifdef MEM_ARB_RAND_DELAY_EN
    logic [3:0] rnd;
    mem_arb_lfsr u_lfsr (.clock(clock), .reset(reset), .value(rnd));
    assign dly = CNT_W'(LATENCY) + CNT_W'(rnd);
`else
    assign dly = CNT_W'(LATENCY);
`endif
    // on a tie the requester not served last wins
    assign gnt_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu);
    assign gnt_lsu = bus.lsu_req_valid && !gnt_ifu;
    assign acc     = state == IDLE && !reset && (gnt_ifu || gnt_lsu);
    assign resp_hs = state == RESP && (owner ? bus.lsu_resp_ready : bus.ifu_resp_ready);
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nxt;
    // WAIT leaves when the counter is about to hit zero so mem_en lands exactly dly cycles after accept
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = acc ? (dly > CNT_W'(1) ? WAIT : ACCESS) : IDLE;
            WAIT:    state_nxt = cnt == CNT_W'(1) ? ACCESS : WAIT;
            ACCESS:  state_nxt = RESP;
            default: state_nxt = resp_hs ? IDLE : RESP;
        endcase
    end
    // combinational outputs are masked during reset so an interrupted transaction never strobes memory
    always_comb begin
        bus.ifu_req_ready  = acc && gnt_ifu;
        bus.lsu_req_ready  = acc && gnt_lsu;
        bus.mem_en         = state == ACCESS && !reset;
        bus.ifu_resp_valid = state == RESP && !reset && !owner;
        bus.lsu_resp_valid = state == RESP && !reset && owner;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            owner         <= 1'b0;
            last_lsu      <= 1'b1;
            cnt           <= '0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.ifu_rdata <= '0;
            bus.lsu_rdata <= '0;
        end else begin
            if (acc) begin
                owner         <= gnt_lsu;
                cnt           <= dly - CNT_W'(1);
                bus.mem_wr    <= gnt_lsu && bus.lsu_wr;
                bus.mem_addr  <= gnt_lsu ? bus.lsu_addr : bus.ifu_addr;
                bus.mem_wdata <= gnt_lsu ? bus.lsu_wdata : '0;
                bus.mem_wstrb <= gnt_lsu ? bus.lsu_wstrb : '0;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == ACCESS && !owner) bus.ifu_rdata <= bus.mem_rdata;
            if (state == ACCESS && owner) bus.lsu_rdata <= bus.mem_rdata;
            if (resp_hs) last_lsu <= owner;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at LATENCY 1, 2, 5 and 8
module tb_mem_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_chk = 0, n_pass = 0;
    int en1 = 0, en2 = 0, en5 = 0, en8 = 0, t_en2 = 0, t_en8 = 0;
    int t_acc, e0, d, bad, lost, bad_d, bad_n, bad_r, ng, dmax;
    int acc_t[4];
    logic ok;
    logic [3:0] order;
    logic [31:0] a;
    mem_arbiter_if b1(), b2(), b5(), b8();
    mem_arbiter #(.LATENCY(1)) d1 (.clock(clk), .reset(rst), .bus(b1.slave));
    mem_arbiter #(.LATENCY(2)) d2 (.clock(clk), .reset(rst), .bus(b2.slave));
    mem_arbiter #(.LATENCY(5)) d5 (.clock(clk), .reset(rst), .bus(b5.slave));
    mem_arbiter #(.LATENCY(8)) d8 (.clock(clk), .reset(rst), .bus(b8.slave));
    function automatic logic [31:0] mem_f(input logic [31:0] x);
        return x == 32'h8000_0000 ? 32'h0000_0413 : {x[15:0], ~x[31:16]};
    endfunction
    // memory returns garbage whenever it is not strobed, so any capture outside ACCESS shows up
    assign b1.mem_rdata = b1.mem_en ? mem_f(b1.mem_addr) : 32'hBAD0_0000 ^ 32'(cyc);
    assign b2.mem_rdata = b2.mem_en ? mem_f(b2.mem_addr) : 32'hBAD1_0000 ^ 32'(cyc);
    assign b5.mem_rdata = b5.mem_en ? mem_f(b5.mem_addr) : 32'hBAD2_0000 ^ 32'(cyc);
    assign b8.mem_rdata = b8.mem_en ? mem_f(b8.mem_addr) : 32'hBAD3_0000 ^ 32'(cyc);
    always @(negedge clk) begin
        en1 += int'(b1.mem_en);
        en5 += int'(b5.mem_en);
        en2 += int'(b2.mem_en);
        en8 += int'(b8.mem_en);
        if (b2.mem_en) t_en2 = cyc;
        if (b8.mem_en) t_en8 = cyc;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    initial begin
        b1.ifu_req_valid = 0; b1.ifu_addr = 0; b1.ifu_resp_ready = 0; b1.lsu_req_valid = 0; b1.lsu_wr = 0;
        b1.lsu_addr = 0; b1.lsu_wdata = 0; b1.lsu_wstrb = 0; b1.lsu_resp_ready = 0;
        b2.ifu_req_valid = 0; b2.ifu_addr = 0; b2.ifu_resp_ready = 0; b2.lsu_req_valid = 0; b2.lsu_wr = 0;
        b2.lsu_addr = 0; b2.lsu_wdata = 0; b2.lsu_wstrb = 0; b2.lsu_resp_ready = 0;
        b5.ifu_req_valid = 0; b5.ifu_addr = 0; b5.ifu_resp_ready = 0; b5.lsu_req_valid = 0; b5.lsu_wr = 0;
        b5.lsu_addr = 0; b5.lsu_wdata = 0; b5.lsu_wstrb = 0; b5.lsu_resp_ready = 0;
        b8.ifu_req_valid = 0; b8.ifu_addr = 0; b8.ifu_resp_ready = 0; b8.lsu_req_valid = 0; b8.lsu_wr = 0;
        b8.lsu_addr = 0; b8.lsu_wdata = 0; b8.lsu_wstrb = 0; b8.lsu_resp_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_ctl", {b1.ifu_req_ready, b1.lsu_req_ready, b1.ifu_resp_valid, b1.lsu_resp_valid,
                        b1.mem_en, b1.mem_wr, b1.mem_wstrb}, 0);
        chk("rst_data", b1.ifu_rdata | b1.lsu_rdata | b1.mem_addr | b1.mem_wdata, 0);
        // IFU read at LATENCY 1
        b1.ifu_resp_ready = 1; b1.lsu_resp_ready = 1;
        @(negedge clk); b1.ifu_req_valid = 1; b1.ifu_addr = 32'h8000_0000; #1;
        chk("t1_accept", {b1.ifu_req_ready, b1.lsu_req_ready}, 2'b10);
        @(negedge clk); b1.ifu_req_valid = 0; #1;
        chk("t1_mem_ctl", {b1.mem_en, b1.mem_wr, b1.mem_wstrb}, 6'b10_0000);
        chk("t1_addr", b1.mem_addr, 32'h8000_0000);
        @(negedge clk); #1;
        chk("t1_resp", {b1.ifu_resp_valid, b1.lsu_resp_valid, b1.mem_en}, 3'b100);
        chk("t1_rdata", b1.ifu_rdata, 32'h0000_0413);
        @(negedge clk); #1;
        chk("t1_resp_drop", b1.ifu_resp_valid, 0);
        chk("t1_en_cnt", en1, 1);
        // LSU write at LATENCY 1
        @(negedge clk);
        b1.lsu_req_valid = 1; b1.lsu_wr = 1; b1.lsu_addr = 32'h8000_1000;
        b1.lsu_wdata = 32'hDEAD_BEEF; b1.lsu_wstrb = 4'b0011; #1;
        chk("t2_accept", {b1.lsu_req_ready, b1.ifu_req_ready}, 2'b10);
        @(negedge clk); b1.lsu_req_valid = 0; #1;
        chk("t2_mem_ctl", {b1.mem_en, b1.mem_wr, b1.mem_wstrb}, 6'b11_0011);
        chk("t2_addr", b1.mem_addr, 32'h8000_1000);
        chk("t2_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("t2_resp", {b1.lsu_resp_valid, b1.ifu_resp_valid, b1.mem_en}, 3'b100);
        chk("t2_rdata", b1.lsu_rdata, 32'h1000_7FFF);
        @(negedge clk); #1;
        chk("t2_resp_drop", {b1.lsu_resp_valid, b1.ifu_resp_valid}, 0);
        chk("t2_en_cnt", en1, 2);
        // both requesting from reset: IFU, LSU, IFU, LSU, back to back
        rst = 1; b1.lsu_wr = 0;
        @(negedge clk); rst = 0;
        b1.ifu_req_valid = 1; b1.lsu_req_valid = 1; ng = 0; order = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            #1;
            if (b1.ifu_req_ready || b1.lsu_req_ready) begin
                order[ng] = b1.lsu_req_ready;
                acc_t[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        b1.ifu_req_valid = 0; b1.lsu_req_valid = 0;
        chk("t3_grants", ng, 4);
        chk("t3_order", order, 4'b1010);
        chk("t3_gap", acc_t[1] - acc_t[0], 3);
        // LATENCY 5 with LSU response stalled and IFU waiting
        b5.ifu_resp_ready = 1;
        @(negedge clk); b5.lsu_req_valid = 1; b5.lsu_addr = 32'h8000_2000; #1;
        chk("t4_accept", b5.lsu_req_ready, 1);
        @(negedge clk); b5.lsu_req_valid = 0; b5.ifu_req_valid = 1; b5.ifu_addr = 32'h8000_3000;
        bad = 0;
        repeat (4) begin
            #1; bad += int'(b5.mem_en | b5.ifu_req_ready);
            @(negedge clk);
        end
        #1;
        chk("t4_early", bad, 0);
        chk("t4_mem_en", {b5.mem_en, b5.mem_wr}, 2'b10);
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            bad += int'(!b5.lsu_resp_valid || b5.lsu_rdata != 32'h2000_7FFF || b5.ifu_req_ready
                        || b5.ifu_resp_valid || b5.mem_en);
        end
        chk("t4_stall", bad, 0);
        @(negedge clk); b5.lsu_resp_ready = 1; #1;
        chk("t4_resp_hs", {b5.lsu_resp_valid, b5.ifu_req_ready}, 2'b10);
        @(negedge clk); b5.lsu_resp_ready = 0; #1;
        chk("t4_ifu_accept", {b5.ifu_req_ready, b5.lsu_resp_valid}, 2'b10);
        @(negedge clk); b5.ifu_req_valid = 0;
        repeat (8) @(negedge clk);
        #1;
        chk("t4_en_cnt", en5, 2);
        chk("t4_ifu_rdata", b5.ifu_rdata, 32'h3000_7FFF);
        // LATENCY 8: full write, then reset while waiting
        b8.lsu_resp_ready = 1; b8.ifu_resp_ready = 1;
        @(negedge clk);
        b8.lsu_req_valid = 1; b8.lsu_wr = 1; b8.lsu_addr = 32'h8000_4000;
        b8.lsu_wdata = 32'h1234_5678; b8.lsu_wstrb = 4'hF; #1;
        chk("t5_accept", b8.lsu_req_ready, 1);
        t_acc = cyc;
        @(negedge clk); b8.lsu_req_valid = 0; #1;
        for (int k = 0; k < 20 && !b8.lsu_resp_valid; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_resp", b8.lsu_resp_valid, 1);
        chk("t5_latency", t_en8 - t_acc, 8);
        chk("t5_lsu_rdata", b8.lsu_rdata, 32'h4000_7FFF);
        @(negedge clk); b8.ifu_req_valid = 1; b8.ifu_addr = 32'h8000_5000; #1;
        chk("t5_accept2", b8.ifu_req_ready, 1);
        @(negedge clk); b8.ifu_req_valid = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; #1;
        chk("t5_rst_ctl", {b8.ifu_req_ready, b8.lsu_req_ready, b8.ifu_resp_valid, b8.lsu_resp_valid,
                           b8.mem_en, b8.mem_wr, b8.mem_wstrb}, 0);
        chk("t5_rst_data", b8.ifu_rdata | b8.lsu_rdata | b8.mem_addr | b8.mem_wdata, 0);
        repeat (12) @(negedge clk);
        #1;
        chk("t5_no_en", {en8[7:0], b8.ifu_resp_valid}, {8'd1, 1'b0});
        // LATENCY 2 read sweep; delay range widens when the random term is built in
`ifdef MEM_ARB_RAND_DELAY_EN
        dmax = 17;
`else
        dmax = 2;
`endif
        b2.ifu_resp_ready = 1;
        lost = 0; bad_d = 0; bad_n = 0; bad_r = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a = 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
            b2.ifu_req_valid = 1; b2.ifu_addr = a; #1;
            for (int k = 0; k < 5 && !b2.ifu_req_ready; k++) begin
                @(negedge clk); #1;
            end
            ok = b2.ifu_req_ready; t_acc = cyc; e0 = en2;
            @(negedge clk); b2.ifu_req_valid = 0; #1;
            for (int k = 0; k < 30 && !b2.ifu_resp_valid; k++) begin
                @(negedge clk); #1;
            end
            d = t_en2 - t_acc;
            if (!ok || !b2.ifu_resp_valid) lost++;
            if (d < 2 || d > dmax) bad_d++;
            if (en2 - e0 != 1 || cyc != t_en2 + 1) bad_n++;
            if (b2.ifu_rdata != mem_f(a)) bad_r++;
        end
        chk("t6_lost", lost, 0);
        chk("t6_delay", bad_d, 0);
        chk("t6_one_en", bad_n, 0);
        chk("t6_data", bad_r, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single DPI-backed data memory port of npc. Shares the memory between the IFU (read-only) and the LSU (read/write) using valid/ready request and response channels with round-robin arbitration. Emulates configurable access latency and guarantees exactly one single-cycle `mem_en` pulse per transaction, because every evaluation of the DPI memory has side effects.

## Interface
- `LATENCY`, 1: cycles from request acceptance to the `mem_en` pulse; legal range 1..255.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ifu_req_valid`  in  1  IFU read request.
- `ifu_req_ready`  out  1  IFU request accepted this cycle.
- `ifu_addr`  in  32  IFU read address.
- `ifu_resp_valid`  out  1  IFU read data valid.
- `ifu_resp_ready`  in  1  IFU takes the response.
- `ifu_rdata`  out  32  IFU read data.
- `lsu_req_valid`  in  1  LSU request.
- `lsu_req_ready`  out  1  LSU request accepted this cycle.
- `lsu_wr`  in  1  1 = write, 0 = read.
- `lsu_addr`  in  32  LSU address.
- `lsu_wdata`  in  32  write data.
- `lsu_wstrb`  in  4  byte strobes.
- `lsu_resp_valid`  out  1  LSU response valid; also issued for writes.
- `lsu_resp_ready`  in  1  LSU takes the response.
- `lsu_rdata`  out  32  LSU read data; for writes, the value the memory returned.
- `mem_en`, `mem_wr`  out  1  memory strobe and direction.
- `mem_addr`, `mem_wdata`  out  32  memory address and write data.
- `mem_wstrb`  out  4  memory byte strobes.
- `mem_rdata`  in  32  memory read data (combinational).

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP. Reset enters IDLE.
- IDLE arbitration:
  - Exactly one of `ifu_req_ready`/`lsu_req_ready` may be high, and only in IDLE.
  - Grant goes to the sole valid requester.
  - If both are valid, grant goes to the requester not granted last. `last_lsu` resets to 1, so IFU wins the first tie.
- On a handshake (valid && ready), register owner, wr, addr, wdata and wstrb. For IFU, force wr=0 and wstrb=0.
- Next state: WAIT if the delay exceeds 1; otherwise ACCESS.
- WAIT: down-counter (9 bit) loaded with delay-1 at accept. Go to ACCESS when it reaches 0.
- ACCESS:
  - `mem_en`=1 for exactly this cycle, with registered wr/addr/wdata/wstrb.
  - Capture `mem_rdata` into the owner's rdata register.
  - Go to RESP.
- RESP:
  - Owner's resp_valid=1; the other requester's resp_valid=0.
  - rdata is held stable until resp_ready.
  - On handshake, go to IDLE and update `last_lsu`.
- `mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_wr` are registered and keep their last values outside ACCESS. Only `mem_en` qualifies them.
- Reset mid-transaction:
  - The pending request is dropped and no `mem_en` is issued.
  - All outputs return to reset values.

## Timing
- Reset values: all `*_ready`, `*_resp_valid` and `mem_en`/`mem_wr` are 0; all rdata, `mem_addr`, `mem_wdata` and `mem_wstrb` are 0.
- Accept in cycle T → `mem_en` in cycle T+delay → resp_valid from T+delay+1.
- Delay = `LATENCY` (plus the random term when configured).
- Minimum transaction, with `LATENCY`=1 and resp_ready held high: 3 cycles (accept, ACCESS, RESP).
- The next accept is possible in the cycle after the response handshake. No overlap, and at most one outstanding transaction.
- A requester holding valid while not granted keeps its request pending; request fields may change until accepted.
- resp_ready held low stalls indefinitely in RESP; the other requester is not served meanwhile.

## Configuration
- `MEM_ARB_RAND_DELAY_EN` defined:
  - Adds a 4-bit LFSR (x^4+x^3+1, seed 4'b1001 at reset, steps every cycle).
  - Its value at accept is added to the delay, giving a total of `LATENCY`..`LATENCY`+15.
- Undefined: delay is exactly `LATENCY`, and no LFSR logic exists.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/WAIT/ACCESS/RESP)
  - `MEM_ARB_LFSR_SEED`
  - counter width constant (9)
- Sub-module `mem_arb_lfsr` (clock, reset, 4-bit value out), instantiated only under `MEM_ARB_RAND_DELAY_EN`.

## Test plan
- `LATENCY`=1, IFU read 0x80000000 with memory returning 0x00000413, resp_ready=1 → `mem_en` high exactly one cycle (T+1), `mem_wr`=0, `ifu_resp_valid` at T+2 with `ifu_rdata`=0x00000413.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wstrb 4'b0011 → one `mem_en` with `mem_wr`=1 and those exact values, then `lsu_resp_valid` for one handshake; `ifu_resp_valid` stays 0.
- Both valid continuously from reset for 4 transactions → grant order IFU, LSU, IFU, LSU.
- `LATENCY`=5, `lsu_resp_ready` low for 10 cycles → `mem_en` at T+5 only, `lsu_rdata` stable while stalled, and the pending IFU request is not accepted until after the LSU handshake.
- `reset` asserted in WAIT with `LATENCY`=8 → `mem_en` never pulses, and all outputs are 0 the cycle after reset.
- With `MEM_ARB_RAND_DELAY_EN` defined, 100 reads with `LATENCY`=2 → every delay lies in 2..17, each transaction issues exactly one `mem_en`, and the data matches.
